// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator. Pixel and line counters step on
//   pix_en, so the block can run from a system clock faster than the pixel
//   rate. Every output is registered and describes the same (hcount, vcount)
//   position in the same cycle.
//
// Ports:
//   clk         - system clock, rising edge
//   sys_rst     - synchronous active-high reset
//   pix_en      - pixel advance enable
//   hcount      - pixel index in line, 0..H_TOTAL-1
//   vcount      - line index in frame, 0..V_TOTAL-1
//   hsync       - horizontal sync, asserted level = H_SYNC_POL
//   vsync       - vertical sync, asserted level = V_SYNC_POL
//   de          - data enable, high inside the visible area
//   line_start  - one-clk strobe when hcount wraps to 0
//   frame_start - one-clk strobe when (hcount, vcount) wraps to (0, 0)
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic          H_POL  = (H_SYNC_POL != 0);
  localparam logic          V_POL  = (V_SYNC_POL != 0);

  // Refuse to elaborate a mode the counters cannot represent.
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $error("vga_timing_gen: sync widths must be at least 1");
  end
  if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
  end

  logic [CW-1:0] r_hcount, r_vcount;
  logic          r_hsync, r_vsync, r_de, r_line_start, r_frame_start;

  logic [CW-1:0] w_h_nxt, w_v_nxt;
  logic          w_ls_nxt, w_fs_nxt;
  logic          w_hs_act, w_vs_act, w_de_nxt;

  always_comb begin
    w_h_nxt  = r_hcount;
    w_v_nxt  = r_vcount;
    w_ls_nxt = 1'b0;
    w_fs_nxt = 1'b0;
    if (pix_en) begin
      if (r_hcount == H_LAST) begin
        w_h_nxt  = '0;
        w_ls_nxt = 1'b1;
        if (r_vcount == V_LAST) begin
          w_v_nxt  = '0;
          w_fs_nxt = 1'b1;
        end else begin
          w_v_nxt = r_vcount + 1'b1;
        end
      end else begin
        w_h_nxt = r_hcount + 1'b1;
      end
    end
  end

  // Syncs and de are decoded from the next counter values so that the
  // registered outputs line up with the registered counters (zero skew).
  // Signed int compares keep degenerate modes (e.g. H_ACTIVE=0) well formed.
  always_comb begin
    w_hs_act = (int'(w_h_nxt) >= H_SYNC_BEG) && (int'(w_h_nxt) < H_SYNC_END);
    w_vs_act = (int'(w_v_nxt) >= V_SYNC_BEG) && (int'(w_v_nxt) < V_SYNC_END);
    w_de_nxt = (int'(w_h_nxt) < H_ACTIVE) && (int'(w_v_nxt) < V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_hcount      <= H_LAST;
      r_vcount      <= V_LAST;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_h_nxt;
      r_vcount      <= w_v_nxt;
      r_hsync       <= w_hs_act ? H_POL : ~H_POL;
      r_vsync       <= w_vs_act ? V_POL : ~V_POL;
      r_de          <= w_de_nxt;
      r_line_start  <= w_ls_nxt;
      r_frame_start <= w_fs_nxt;
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default 640x480 mode, a
// small 14x7 mode with active-high syncs, and a degenerate H_TOTAL=1 mode)
// share one reset and one pix_en. Expected outputs are pushed into a queue
// at stimulus time and popped by an independent monitor after each edge.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sys_rst = 1'b1;
  logic pix_en  = 1'b0;

  logic [9:0] hc0, vc0;
  logic [3:0] hc1, vc1;
  logic [2:0] hc2, vc2;
  logic       hs [3];
  logic       vs [3];
  logic       den[3];
  logic       ls [3];
  logic       fs [3];

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .CW(10)
  ) u_dut0 (
    .clk(clk), .sys_rst(sys_rst), .pix_en(pix_en),
    .hcount(hc0), .vcount(vc0), .hsync(hs[0]), .vsync(vs[0]), .de(den[0]),
    .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .CW(4)
  ) u_dut1 (
    .clk(clk), .sys_rst(sys_rst), .pix_en(pix_en),
    .hcount(hc1), .vcount(vc1), .hsync(hs[1]), .vsync(vs[1]), .de(den[1]),
    .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(0), .H_FP(0), .H_SYNC(1), .H_BP(0),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(0), .V_SYNC_POL(1), .CW(3)
  ) u_dut2 (
    .clk(clk), .sys_rst(sys_rst), .pix_en(pix_en),
    .hcount(hc2), .vcount(vc2), .hsync(hs[2]), .vsync(vs[2]), .de(den[2]),
    .line_start(ls[2]), .frame_start(fs[2])
  );

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    obs_t e[3];
    int   ph;
  } sb_t;

  sb_t  q[$];
  obs_t act[3];

  assign act[0] = {hc0, vc0, hs[0], vs[0], den[0], ls[0], fs[0]};
  assign act[1] = {6'd0, hc1, 6'd0, vc1, hs[1], vs[1], den[1], ls[1], fs[1]};
  assign act[2] = {7'd0, hc2, 7'd0, vc2, hs[2], vs[2], den[2], ls[2], fs[2]};

  // Mode table, one column per instance.
  int HA[3] = '{640, 8, 0};
  int HF[3] = '{16, 2, 0};
  int HS[3] = '{96, 3, 1};
  int HB[3] = '{48, 1, 0};
  int VA[3] = '{480, 4, 2};
  int VF[3] = '{10, 1, 1};
  int VS[3] = '{2, 1, 1};
  int VB[3] = '{33, 1, 1};
  int HP[3] = '{0, 1, 0};
  int VP[3] = '{0, 1, 1};

  int mh[3];
  int mv[3];

  int checks = 0;
  int errors = 0;

  // Reference behaviour written straight from the timing definitions.
  function automatic obs_t model(input int i, input logic r, input logic en);
    obs_t o;
    int   ht, vt;
    logic hpol, vpol;
    ht   = HA[i] + HF[i] + HS[i] + HB[i];
    vt   = VA[i] + VF[i] + VS[i] + VB[i];
    hpol = (HP[i] != 0);
    vpol = (VP[i] != 0);
    o    = '0;
    if (r) begin
      mh[i] = ht - 1;
      mv[i] = vt - 1;
    end else if (en) begin
      if (mh[i] == ht - 1) begin
        mh[i] = 0;
        o.ls  = 1'b1;
        if (mv[i] == vt - 1) begin
          mv[i] = 0;
          o.fs  = 1'b1;
        end else begin
          mv[i] = mv[i] + 1;
        end
      end else begin
        mh[i] = mh[i] + 1;
      end
    end
    o.h = 10'(mh[i]);
    o.v = 10'(mv[i]);
    if (r) begin
      o.hs = ~hpol;
      o.vs = ~vpol;
      o.de = 1'b0;
    end else begin
      o.hs = (mh[i] >= HA[i] + HF[i] && mh[i] < HA[i] + HF[i] + HS[i]) ? hpol : ~hpol;
      o.vs = (mv[i] >= VA[i] + VF[i] && mv[i] < VA[i] + VF[i] + VS[i]) ? vpol : ~vpol;
      o.de = (mh[i] < HA[i]) && (mv[i] < VA[i]);
    end
    return o;
  endfunction

  task automatic step(input logic r, input logic en, input int ph);
    sb_t it;
    @(negedge clk);
    sys_rst = r;
    pix_en  = en;
    for (int i = 0; i < 3; i++) it.e[i] = model(i, r, en);
    it.ph = ph;
    q.push_back(it);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, got, exp);
    end
  endtask

  // Measurements taken by the monitor during the free-running phase.
  int cnt_hs0_low = 0;
  int cnt_de0     = 0;
  int cnt_ls0     = 0;
  int cnt_fs0     = 0;
  int cnt_fs1     = 0;
  int cnt_ls2     = 0;
  int last_fs1    = -1;
  int gap_fs1     = 0;
  int cyc         = 0;

  initial begin : monitor
    sb_t it;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        cyc++;
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (act[i] !== it.e[i]) begin
            errors++;
            $display("FAIL dut%0d cyc %0d: actual h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b, required h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                     i, cyc, act[i].h, act[i].v, act[i].hs, act[i].vs, act[i].de, act[i].ls, act[i].fs,
                     it.e[i].h, it.e[i].v, it.e[i].hs, it.e[i].vs, it.e[i].de, it.e[i].ls, it.e[i].fs);
          end
        end
        if (it.ph == 2) begin
          if (act[0].hs == 1'b0) cnt_hs0_low++;
          if (act[0].de) cnt_de0++;
          if (act[0].ls) cnt_ls0++;
          if (act[0].fs) cnt_fs0++;
          if (act[2].ls) cnt_ls2++;
          if (act[1].fs) begin
            cnt_fs1++;
            if (last_fs1 >= 0) gap_fs1 = cyc - last_fs1;
            last_fs1 = cyc;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int wait_cnt;
    // Reset, including a cycle where pix_en must be ignored.
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 1);
    // Free run: default DUT ends at (797,1), one frame of the small mode is 98.
    for (int n = 0; n < 1598; n++) step(1'b0, 1'b1, 2);
    // 1,0,0,1 pattern straddling a default-mode line wrap.
    for (int n = 0; n < 10; n++) begin
      step(1'b0, 1'b1, 3);
      step(1'b0, 1'b0, 3);
      step(1'b0, 1'b0, 3);
      step(1'b0, 1'b1, 3);
    end
    // Mid-frame reset with pix_en high, then restart.
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 4);
    step(1'b1, 1'b1, 4);
    for (int n = 0; n < 120; n++) step(1'b0, 1'b1, 4);
    step(1'b0, 1'b0, 4);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d pending, required 0", q.size());
    end

    check_int("hsync_low_clks_2lines", cnt_hs0_low, 192);
    check_int("de_clks_2lines", cnt_de0, 1280);
    check_int("line_start_2lines", cnt_ls0, 2);
    check_int("frame_start_default", cnt_fs0, 1);
    check_int("small_frame_period", gap_fs1, 98);
    check_int("small_frame_count", cnt_fs1, 17);
    check_int("htotal1_line_start", cnt_ls2, 1598);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
